// File: rtl/mod_counter_cascade_if.sv
// mod_counter_cascade_if: control/status bundle of one counter stage; dir exists only with MOD_COUNTER_DOWN_EN
interface mod_counter_cascade_if #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 8
);
  logic              en_ct;
`ifdef MOD_COUNTER_DOWN_EN
  logic              dir;
`endif
  logic              rst_ct;
  logic              ld;
  logic [WIDTH-1:0]  ld_val;
  logic [PASS_W-1:0] pass_tgt;
  logic [WIDTH-1:0]  count;
  logic              carry_out;
  logic              tc;
  logic [PASS_W-1:0] pass_cnt;
  logic              done;
`ifdef MOD_COUNTER_DOWN_EN
  modport master (output en_ct, dir, rst_ct, ld, ld_val, pass_tgt,
                  input count, carry_out, tc, pass_cnt, done);
  modport slave  (input en_ct, dir, rst_ct, ld, ld_val, pass_tgt,
                  output count, carry_out, tc, pass_cnt, done);
`else
  modport master (output en_ct, rst_ct, ld, ld_val, pass_tgt,
                  input count, carry_out, tc, pass_cnt, done);
  modport slave  (input en_ct, rst_ct, ld, ld_val, pass_tgt,
                  output count, carry_out, tc, pass_cnt, done);
`endif
endinterface

// File: rtl/mod_counter_cascade.sv
// mod_counter_cascade: modulo-N counter with load, pass counter and cascade carry; MOD_COUNTER_DOWN_EN adds down counting
module mod_counter_cascade #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int PASS_W  = 8
) (
  input logic clk,
  input logic rst,
  mod_counter_cascade_if.slave b
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic              wrap_pt;
  logic [WIDTH-1:0]  step;
  logic [WIDTH-1:0]  wrap_val;
  logic [PASS_W-1:0] pass_nxt;
`ifdef MOD_COUNTER_DOWN_EN
  assign wrap_pt  = b.dir ? b.count == '0 : b.count == MAX;
  assign step     = b.dir ? b.count - 1'b1 : b.count + 1'b1;
  assign wrap_val = b.dir ? MAX : '0;
`else
  assign wrap_pt  = b.count == MAX;
  assign step     = b.count + 1'b1;
  assign wrap_val = '0;
`endif
  // carry is deliberately not gated by ld/rst_ct so a downstream stage still advances
  assign b.carry_out = b.en_ct & ~b.done & wrap_pt;
  assign pass_nxt    = b.pass_cnt + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      b.count    <= '0;
      b.pass_cnt <= '0;
      b.tc       <= 1'b0;
      b.done     <= 1'b0;
    end else if (b.rst_ct) begin
      b.count    <= '0;
      b.pass_cnt <= '0;
      b.tc       <= 1'b0;
      b.done     <= 1'b0;
    end else if (b.ld) begin
      b.count <= b.ld_val > MAX ? MAX : b.ld_val;
      b.tc    <= 1'b0;
    end else if (b.carry_out) begin
      b.count    <= wrap_val;
      b.pass_cnt <= pass_nxt;
      b.tc       <= 1'b1;
      b.done     <= b.pass_tgt != '0 && pass_nxt == b.pass_tgt;
    end else if (b.en_ct && !b.done) begin
      b.count <= step;
      b.tc    <= 1'b0;
    end else begin
      b.tc <= 1'b0;
    end
endmodule

// File: doc/mod_counter_cascade.md
Name: mod_counter_cascade

Overview:
- Parametrised modulo-N counter with synchronous clear, parallel load and a registered terminal-count pulse.
- Also provides a combinational carry for cascading and a pass counter that stops the block after a programmed number of full cycles.
- Used as the index/loop generator for ELM hidden-neuron and sample iteration. Instances are chained via carry_out -> en_ct to form nested loops.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- PASS_W, 8, width of the pass counter and the pass target.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en_ct  input  1  count enable / carry-in.
- rst_ct  input  1  synchronous clear of count, pass_cnt, tc and done.
- ld  input  1  synchronous load of ld_val into count.
- ld_val  input  WIDTH  load value.
- pass_tgt  input  PASS_W  number of full cycles before done; 0 = free-running.
- count  output  WIDTH  current count, registered.
- carry_out  output  1  combinational wrap indication for cascading.
- tc  output  1  registered one-cycle pulse following a wrap.
- pass_cnt  output  PASS_W  number of completed wraps, registered.
- done  output  1  sticky; set when pass_cnt reaches pass_tgt.

Behaviour:
- Reset (rst=0, asynchronous): count=0, pass_cnt=0, tc=0, done=0. All outputs are valid immediately; carry_out=0 while count=0 and MODULUS>1.
- Per-edge priority: rst > rst_ct > ld > en_ct > hold.
- rst_ct=1: count<=0, pass_cnt<=0, tc<=0, done<=0, regardless of ld or en_ct.
- ld=1 (rst_ct=0):
  - count<=ld_val; if ld_val>=MODULUS, count<=MODULUS-1 (clamp).
  - pass_cnt and done are unchanged; tc<=0.
  - Load is honoured even while done=1.
- en_ct=1, done=0, no ld/rst_ct:
  - If count<MODULUS-1: count<=count+1.
  - If count==MODULUS-1 (wrap): count<=0; pass_cnt<=pass_cnt+1, wrapping modulo 2^PASS_W; tc<=1 on that edge, so it is visible the cycle after the wrap edge for exactly one cycle. If pass_tgt!=0 and pass_cnt+1==pass_tgt, done<=1 on the same edge.
- done=1: en_ct is ignored. count holds, at 0 after the final wrap; pass_cnt holds; carry_out=0. Only rst, rst_ct or ld change state.
- tc is 0 on every edge that is not a wrap edge, so back-to-back wraps (MODULUS=2, en_ct held) give tc alternating 0/1.
- carry_out = en_ct & ~done & (count==MODULUS-1), purely combinational; it is not gated by ld or rst_ct. A cascaded downstream instance therefore advances in the same edge the upstream instance wraps.
- pass_tgt is sampled every cycle, not latched. Changing it mid-run takes effect at the next wrap comparison. Lowering it below pass_cnt means done is not reached until pass_cnt wraps around.
- en_ct=0: full hold, tc<=0.

Optional Feature:
- Macro: MOD_COUNTER_DOWN_EN.
- Defined:
  - Adds input port dir (1 bit, after en_ct); dir=0 counts up exactly as above.
  - dir=1 counts down: count<=count-1; the wrap occurs at count==0 -> MODULUS-1, with the pass_cnt/tc/done updates identical to the up wrap.
  - carry_out = en_ct & ~done & (dir ? count==0 : count==MODULUS-1).
  - dir may change on any cycle; it takes effect on that edge.
- Undefined: dir port absent; up-count only.

Test Plan (WIDTH=4, MODULUS=10, PASS_W=8):
- Release rst, hold en_ct=1, pass_tgt=0 for 25 cycles -> count 0..9,0..9,0..4; carry_out high when count=9; tc high the cycle after count goes 9->0 (twice); pass_cnt=2; done=0.
- pass_tgt=3, en_ct=1 continuous -> done rises on the edge of the 3rd 9->0 wrap; count stays 0, pass_cnt=3, carry_out=0 thereafter despite en_ct=1; rst_ct pulse -> all outputs 0 and counting resumes.
- count=5: assert ld=1, ld_val=7 with en_ct=1 -> count=7 (load wins over increment); then ld_val=12 -> count=9 (clamped); rst_ct and ld together -> count=0.
- Assert rst=0 asynchronously mid-cycle at count=6, pass_cnt=1 -> count, pass_cnt, tc and done go to 0 without a clock edge; they stay 0 until rst=1.
- Two instances chained (A.carry_out -> B.en_ct), A en_ct=1 for 100 cycles -> B.count=0 and B.pass_cnt=1 at cycle 100; B increments exactly on A's 9->0 edges.
- With MOD_COUNTER_DOWN_EN, dir=1 from count=2 -> 1,0,9,8; tc pulses after the 0->9 edge; flip dir=0 at count=8 -> 9,0 with a wrap.
